// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// reset-cause bit positions and a small elaboration helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    localparam int CAUSE_POR      = 0;
    localparam int CAUSE_LOCK     = 1;
    localparam int CAUSE_REQ_BASE = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and its environment. The slave
// modport is the sequencer; the master modport is the surrounding system.
interface reset_sequencer_if #(
    parameter int NUM_CH  = 4,
    parameter int NUM_REQ = 3,
    parameter int CYC_W   = 12
);
    import reset_seq_pkg::*;

    logic               phi2;
    logic [CYC_W-1:0]   phi2_cycle;
    logic               clk_locked;
    logic               modules_ready;
    logic [NUM_REQ-1:0] reset_req_n;
    logic               cause_clr;
    logic [NUM_CH-1:0]  ch_reset_n;
    logic               all_released;
    logic [NUM_REQ+1:0] reset_cause;
    state_t             state;

    modport master (
        output phi2, phi2_cycle, clk_locked, modules_ready, reset_req_n, cause_clr,
        input  ch_reset_n, all_released, reset_cause, state
    );

    modport slave (
        input  phi2, phi2_cycle, clk_locked, modules_ready, reset_req_n, cause_clr,
        output ch_reset_n, all_released, reset_cause, state
    );

endinterface

// File: rtl/reset_req_debounce.sv
// Accepts an active-low reset request only after it has stayed low for
// DEBOUNCE_CYCLES consecutive clocks; any high clock drops it immediately.
module reset_req_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req_n_i,
    output logic active_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (req_n_i) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The current low clock counts, so the request is live on its N-th low clock.
    assign active_o = !req_n_i && (cnt_q == LAST);

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: holds all domains in reset during faults, then
// releases them in index order on phi2-aligned ticks. Optional request
// debouncing is enabled with RESET_SEQ_DEBOUNCE_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int NUM_REQ     = 3,
    parameter int HOLD_CYCLES = 10,
    parameter int STAGE_GAP   = 2,
    parameter int ALIGN_CYCLE = 2,
    parameter int CYC_W       = 12
`ifdef RESET_SEQ_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic            clk,
    input  logic            reset_n,
    reset_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(max2(HOLD_CYCLES, STAGE_GAP) + 1);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);
    localparam logic [CYC_W-1:0] ALIGN     = CYC_W'(ALIGN_CYCLE);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_CH-1:0]  ch_q, ch_d;
    logic [NUM_REQ+1:0] cause_q, cause_d;

    logic [NUM_REQ-1:0] req_act;
    logic               fault;
    logic               tick;
    logic               rel_fire;
    logic [IDX_W-1:0]   rel_idx;

`ifdef RESET_SEQ_DEBOUNCE_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_deb
        reset_req_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (clk),
            .reset_n  (reset_n),
            .req_n_i  (bus.reset_req_n[g]),
            .active_o (req_act[g])
        );
    end
`else
    assign req_act = ~bus.reset_req_n;
`endif

    assign fault = !bus.clk_locked || !bus.modules_ready || (|req_act);
    assign tick  = !bus.phi2 && (bus.phi2_cycle == ALIGN);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            ch_q    <= '0;
            cause_q <= (NUM_REQ + 2)'(1) << CAUSE_POR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ch_q    <= ch_d;
            cause_q <= cause_d;
        end
    end

    // cnt counts ticks since entering HOLD, or since the last channel release.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rel_fire = 1'b0;
        rel_idx  = idx_q;
        if (fault) begin
            state_d = ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ASSERT: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                HOLD: begin
                    if (tick) begin
                        if (cnt_q == HOLD_LAST) begin
                            rel_fire = 1'b1;
                            rel_idx  = '0;
                            cnt_d    = '0;
                            idx_d    = IDX_W'(1);
                            if (NUM_CH == 1) begin
                                state_d = RUN;
                            end else begin
                                state_d = RELEASE;
                            end
                        end else if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (tick) begin
                        if (cnt_q == GAP_LAST) begin
                            rel_fire = 1'b1;
                            rel_idx  = idx_q;
                            cnt_d    = '0;
                            if (idx_q == IDX_LAST) begin
                                state_d = RUN;
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end else if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = ASSERT;
                end
            endcase
        end
    end

    // Set conditions are applied after the clear so they win on the same clock.
    always_comb begin
        ch_d = ch_q;
        if (fault) begin
            ch_d = '0;
        end else if (rel_fire) begin
            ch_d[rel_idx] = 1'b1;
        end

        cause_d = bus.cause_clr ? '0 : cause_q;
        if (!bus.clk_locked) begin
            cause_d[CAUSE_LOCK] = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_act[i]) begin
                cause_d[CAUSE_REQ_BASE + i] = 1'b1;
            end
        end
    end

    assign bus.ch_reset_n   = ch_q;
    assign bus.all_released = (state_q == RUN);
    assign bus.reset_cause  = cause_q;
    assign bus.state        = state_q;

endmodule
